// File: rtl/input_debouncer_if.sv
// Raw switch input and debounced outputs of input_debouncer.
// master drives the raw level; slave is the debouncer itself.
interface input_debouncer_if;
   logic data_i;
   logic data_o;
   logic busy_o;

   modport master (output data_i, input data_o, input busy_o);
   modport slave  (input data_i, output data_o, output busy_o);
endinterface

// File: rtl/input_debouncer.sv
// Synchronises and debounces a bouncing single-bit input into the clk domain.
// Define DEBOUNCE_SYNC3_EN for a 3-flop synchroniser (default is 2 flops).
module input_debouncer #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input_debouncer_if.slave    bus
);

`ifdef DEBOUNCE_SYNC3_EN
   localparam int SYNC_N = 3;
`else
   localparam int SYNC_N = 2;
`endif

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_N-1:0] sync_ff;
   logic              sync_q;
   logic [CNT_W-1:0]  cnt;
   logic              data_q;

   assign sync_q = sync_ff[SYNC_N-1];

   // Plain flop chain with nothing in between, to give metastability time to settle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_ff <= '0;
      end else begin
         sync_ff <= {sync_ff[SYNC_N-2:0], bus.data_i};
      end
   end

   // Any return to the current output level discards the partial count, so one glitch
   // restarts qualification; the clear at CNT_LAST keeps the counter from ever wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         data_q <= 1'b0;
      end else if (sync_q == data_q) begin
         cnt    <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt    <= '0;
         data_q <= sync_q;
      end else begin
         cnt    <= cnt + CNT_W'(1);
      end
   end

   assign bus.data_o = data_q;
   assign bus.busy_o = (cnt != '0);

endmodule

// File: tb/tb_input_debouncer.sv
// Directed testbench for input_debouncer with DEBOUNCE_CYCLES = 4 and = 1.
// Latencies follow the synchroniser depth selected by DEBOUNCE_SYNC3_EN.
module tb_input_debouncer;

`ifdef DEBOUNCE_SYNC3_EN
   localparam int SYNC_N = 3;
`else
   localparam int SYNC_N = 2;
`endif
   localparam int LAT  = SYNC_N + 4;
   localparam int LAT1 = SYNC_N + 1;

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;
   int   rises = 0;
   logic prev_o = 1'b0;

   always #5 clk = ~clk;

   input_debouncer_if bus  ();
   input_debouncer_if bus1 ();

   input_debouncer #(.DEBOUNCE_CYCLES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   input_debouncer #(.DEBOUNCE_CYCLES(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1.slave)
   );

   // Stand-in for the downstream rising-edge detector on the main instance.
   always @(negedge clk) begin
      if (bus.data_o === 1'b1 && prev_o === 1'b0) rises++;
      prev_o = bus.data_o;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      bus.data_i  = 1'b1;
      bus1.data_i = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      vectors++;
      if (bus.data_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_immediate: data_o=%b busy_o=%b, want 0 0", bus.data_o, bus.busy_o);
      end
      tick(3);
      vectors++;
      if (bus.data_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_held: data_o=%b busy_o=%b, want 0 0", bus.data_o, bus.busy_o);
      end
      reset = 1'b0;
      for (int e = 1; e <= LAT; e++) begin
         tick(1);
         vectors++;
         if (bus.data_o !== (e >= LAT) || bus.busy_o !== (e > SYNC_N && e < LAT)) begin
            miscompares++;
            $display("[TB] FAIL reset_release edge %0d: data_o=%b busy_o=%b, want %b %b",
                     e, bus.data_o, bus.busy_o, (e >= LAT), (e > SYNC_N && e < LAT));
         end
      end
   endtask

   task automatic test_clean_fall();
      bus.data_i = 1'b0;
      for (int e = 1; e <= LAT; e++) begin
         tick(1);
         vectors++;
         if (bus.data_o !== (e < LAT) || bus.busy_o !== (e > SYNC_N && e < LAT)) begin
            miscompares++;
            $display("[TB] FAIL clean_fall edge %0d: data_o=%b busy_o=%b, want %b %b",
                     e, bus.data_o, bus.busy_o, (e < LAT), (e > SYNC_N && e < LAT));
         end
      end
   endtask

   task automatic test_glitch();
      bus.data_i = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         if (e == 4) bus.data_i = 1'b0;
         tick(1);
         vectors++;
         if (bus.data_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL glitch edge %0d: data_o=%b, want 0", e, bus.data_o);
         end
      end
      vectors++;
      if (bus.busy_o !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL glitch_busy: busy_o=%b, want 0", bus.busy_o);
      end
   endtask

   task automatic test_clean_rise();
      bus.data_i = 1'b1;
      for (int e = 1; e <= LAT; e++) begin
         tick(1);
         vectors++;
         if (bus.data_o !== (e >= LAT) || bus.busy_o !== (e > SYNC_N && e < LAT)) begin
            miscompares++;
            $display("[TB] FAIL clean_rise edge %0d: data_o=%b busy_o=%b, want %b %b",
                     e, bus.data_o, bus.busy_o, (e >= LAT), (e > SYNC_N && e < LAT));
         end
      end
   endtask

   task automatic test_bounce();
      logic [3:0] pattern;
      bus.data_i = 1'b0;
      tick(LAT + 2);
      pattern = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         bus.data_i = pattern[3-k];
         for (int c = 0; c < 2; c++) begin
            tick(1);
            vectors++;
            if (bus.data_o !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL bounce level %0d: data_o=%b, want 0", k, bus.data_o);
            end
         end
      end
      bus.data_i = 1'b1;
      for (int e = 1; e <= LAT; e++) begin
         tick(1);
         vectors++;
         if (bus.data_o !== (e >= LAT)) begin
            miscompares++;
            $display("[TB] FAIL bounce_settle edge %0d: data_o=%b, want %b", e, bus.data_o, (e >= LAT));
         end
      end
   endtask

   task automatic test_mid_reset();
      bus.data_i = 1'b0;
      tick(SYNC_N + 2);
      vectors++;
      if (bus.busy_o !== 1'b1 || bus.data_o !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL mid_reset_pre: data_o=%b busy_o=%b, want 1 1", bus.data_o, bus.busy_o);
      end
      reset = 1'b1;
      #1;
      vectors++;
      if (bus.data_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL mid_reset_async: data_o=%b busy_o=%b, want 0 0", bus.data_o, bus.busy_o);
      end
      tick(1);
      reset = 1'b0;
      bus.data_i = 1'b1;
      for (int e = 1; e <= LAT; e++) begin
         tick(1);
         vectors++;
         if (bus.data_o !== (e >= LAT)) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_requal edge %0d: data_o=%b, want %b", e, bus.data_o, (e >= LAT));
         end
      end
   endtask

   task automatic test_min_cycles();
      bus1.data_i = 1'b1;
      for (int e = 1; e <= LAT1; e++) begin
         tick(1);
         vectors++;
         if (bus1.data_o !== (e >= LAT1) || bus1.busy_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL min_rise edge %0d: data_o=%b busy_o=%b, want %b 0",
                     e, bus1.data_o, bus1.busy_o, (e >= LAT1));
         end
      end
      bus1.data_i = 1'b0;
      for (int e = 1; e <= LAT1; e++) begin
         tick(1);
         vectors++;
         if (bus1.data_o !== (e < LAT1)) begin
            miscompares++;
            $display("[TB] FAIL min_fall edge %0d: data_o=%b, want %b", e, bus1.data_o, (e < LAT1));
         end
      end
   endtask

   task automatic test_back_to_back();
      int r0;
      bus.data_i = 1'b0;
      tick(LAT + 2);
      r0 = rises;
      for (int p = 0; p < 2; p++) begin
         bus.data_i = 1'b1; tick(1);
         bus.data_i = 1'b0; tick(1);
         bus.data_i = 1'b1; tick(LAT + 3);
         bus.data_i = 1'b0; tick(1);
         bus.data_i = 1'b1; tick(1);
         bus.data_i = 1'b0; tick(LAT + 3);
      end
      vectors++;
      if (rises - r0 !== 2) begin
         miscompares++;
         $display("[TB] FAIL press_pulses: got %0d rising edges, want 2", rises - r0);
      end
      vectors++;
      if (bus.data_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL press_final: data_o=%b busy_o=%b, want 0 0", bus.data_o, bus.busy_o);
      end
   endtask

   initial begin
      reset       = 1'b0;
      bus.data_i  = 1'b0;
      bus1.data_i = 1'b0;
      test_reset();
      test_clean_fall();
      test_glitch();
      test_clean_rise();
      test_bounce();
      test_mid_reset();
      test_min_cycles();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
